// File: rtl/antisat_pkg.sv
// Shared types and helpers for the Anti-SAT keyed output lock.
// The key register holds k_l in its low half and k_r in its high half.
package antisat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_t;

    // Widest supported tap count; key_split works on a zero-padded key of twice this width.
    localparam int HALF_MAX_W = 32;
    localparam int KEY_MAX_W  = 2 * HALF_MAX_W;

    typedef struct packed {
        logic [HALF_MAX_W-1:0] k_r;
        logic [HALF_MAX_W-1:0] k_l;
    } key_halves_t;

    function automatic int key_width(input int in_w);
        return 2 * in_w;
    endfunction

    function automatic int idx_width(input int key_w);
        return $clog2(key_w + 1);
    endfunction

    function automatic key_halves_t key_split(input logic [KEY_MAX_W-1:0] key, input int in_w);
        key_halves_t h;
        h = '0;
        for (int i = 0; i < HALF_MAX_W; i++) begin
            if (i < in_w) begin
                h.k_l[i] = key[i];
                h.k_r[i] = key[i + in_w];
            end
        end
        return h;
    endfunction

endpackage

// File: rtl/antisat_core.sv
// Combinational Anti-SAT block: flip fires only when the taps match ~k_l
// and differ from ~k_r, so any key with k_l == k_r never flips.
module antisat_core #(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0] tap_in,
    input  logic [IN_W-1:0] k_l,
    input  logic [IN_W-1:0] k_r,
    output logic            g,
    output logic            gb,
    output logic            flip
);

    assign g    = &(tap_in ^ k_l);
    assign gb   = ~&(tap_in ^ k_r);
    assign flip = g & gb;

endmodule

// File: rtl/antisat_keyed_lock.sv
// Keyed Anti-SAT output lock: serial key loader, Anti-SAT core, output
// blanking/inversion stage and a saturating counter of armed flip cycles.
module antisat_keyed_lock
    import antisat_pkg::*;
#(
    parameter int IN_W    = 3,
    parameter int OUT_W   = 7,
    parameter int REG_OUT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             key_clear,
    input  logic [IN_W-1:0]  tap_in,
    input  logic [OUT_W-1:0] func_in,
    output logic [OUT_W-1:0] func_out,
    output logic             armed,
    output logic [CNT_W-1:0] flip_cnt
);

    localparam int KEY_W = key_width(IN_W);
    localparam int IDX_W = idx_width(KEY_W);

    state_t            state_q;
    logic [KEY_W-1:0]  key_q;
    logic [IDX_W-1:0]  idx_q;
    logic              armed_q;
    logic [CNT_W-1:0]  flip_cnt_q;

    logic [IN_W-1:0]   k_l;
    logic [IN_W-1:0]   k_r;
    logic              core_g;
    logic              core_gb;
    logic              flip;
    logic              accept;
    logic [OUT_W-1:0]  func_d;

    assign key_ready = (state_q != ARMED);
    assign accept    = key_valid & key_ready;

    assign k_l = IN_W'(key_split(KEY_MAX_W'(key_q), IN_W));
    assign k_r = IN_W'(key_split(KEY_MAX_W'(key_q), IN_W) >> HALF_MAX_W);

    antisat_core #(.IN_W(IN_W)) u_core (
        .tap_in (tap_in),
        .k_l    (k_l),
        .k_r    (k_r),
        .g      (core_g),
        .gb     (core_gb),
        .flip   (flip)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers take non-blocking assignments; key_clear shares the reset path so it beats a same-cycle accept.
        if (rst || key_clear) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (accept) begin
                        key_q[idx_q] <= key_in;
                        idx_q        <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(KEY_W - 1)) begin
                            state_q <= ARMED;
                            armed_q <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns func_d and no latch is inferred.
        func_d = '0;
        if (armed_q) begin
            func_d = func_in ^ {OUT_W{flip}};
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [OUT_W-1:0] func_q;
        always_ff @(posedge clk) begin
            if (rst) func_q <= '0;
            else     func_q <= func_d;
        end
        assign func_out = func_q;
    end else begin : g_comb_out
        assign func_out = func_d;
    end

    // Counted from the raw core terms; their AND is the flip that drives the outputs.
    always_ff @(posedge clk) begin
        if (rst || key_clear) begin
            flip_cnt_q <= '0;
        end else if (armed_q && core_g && core_gb && (flip_cnt_q != '1)) begin
            flip_cnt_q <= flip_cnt_q + CNT_W'(1);
        end
    end

    assign armed    = armed_q;
    assign flip_cnt = flip_cnt_q;

endmodule

// File: tb/tb_antisat_keyed_lock.sv
// Directed bench for antisat_keyed_lock: registered, combinational and
// narrow-counter instances share one stimulus stream.
module tb_antisat_keyed_lock;
    import antisat_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_in;
    logic       key_valid;
    logic       key_clear;
    logic [2:0] tap_in;
    logic [6:0] func_in;

    logic       r_ready, c_ready, s_ready;
    logic       r_armed, c_armed, s_armed;
    logic [6:0] r_func, c_func, s_func;
    logic [7:0] r_flip, c_flip;
    logic [1:0] s_flip;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    antisat_keyed_lock #(.IN_W(3), .OUT_W(7), .REG_OUT(1), .CNT_W(8)) dut_r (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(r_ready),
        .key_clear(key_clear), .tap_in(tap_in), .func_in(func_in), .func_out(r_func),
        .armed(r_armed), .flip_cnt(r_flip)
    );

    antisat_keyed_lock #(.IN_W(3), .OUT_W(7), .REG_OUT(0), .CNT_W(8)) dut_c (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(c_ready),
        .key_clear(key_clear), .tap_in(tap_in), .func_in(func_in), .func_out(c_func),
        .armed(c_armed), .flip_cnt(c_flip)
    );

    antisat_keyed_lock #(.IN_W(3), .OUT_W(7), .REG_OUT(1), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(s_ready),
        .key_clear(key_clear), .tap_in(tap_in), .func_in(func_in), .func_out(s_func),
        .armed(s_armed), .flip_cnt(s_flip)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        key_valid = 1'b1;
        key_in    = b;
        tick();
        key_valid = 1'b0;
        key_in    = 1'b0;
    endtask

    // Bits go out LSB first: k[0] is the first accepted bit.
    task automatic send_bits(input logic [5:0] k, input int n);
        for (int i = 0; i < n; i++) send_bit(k[i]);
    endtask

    logic [6:0] prev_c;
    int         exp_flips;

    initial begin
        rst = 1'b1; key_in = 1'b0; key_valid = 1'b0; key_clear = 1'b0;
        tap_in = 3'b000; func_in = 7'h7F;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Pre-key blanking
        check("rst_armed",   r_armed, 0);
        check("rst_ready",   r_ready, 1);
        check("rst_func_r",  r_func, 7'h00);
        check("rst_func_c",  c_func, 7'h00);
        check("rst_flipcnt", r_flip, 0);
        check("rst_state",   32'(dut_r.state_q), 32'(IDLE));
        check("rst_key",     dut_r.key_q, 6'b000000);

        // Correct key 1,0,1,1,0,1 -> k_l = k_r = 3'b101
        func_in = 7'h55;
        send_bits(6'b101101, 5);
        check("load5_armed", r_armed, 0);
        check("load5_ready", r_ready, 1);
        send_bit(1'b1);
        check("load6_armed", r_armed, 1);
        check("load6_ready", r_ready, 0);
        check("load6_func_r_blank", r_func, 7'h00);
        check("load6_func_c_live",  c_func, 7'h55);
        check("load6_key",   dut_r.key_q, 6'b101101);

        // Sweep all taps with key_valid held high in ARMED
        key_valid = 1'b1;
        key_in    = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tap_in = 3'(t);
            tick();
            check($sformatf("good_r_tap%0d", t), r_func, 7'h55);
            check($sformatf("good_c_tap%0d", t), c_func, 7'h55);
        end
        key_valid = 1'b0;
        check("good_flipcnt",  r_flip, 0);
        check("armed_key_hold", dut_r.key_q, 6'b101101);

        // Plain clear from ARMED
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check("clr_armed",  r_armed, 0);
        check("clr_func_c", c_func, 7'h00);
        check("clr_key",    dut_r.key_q, 6'b000000);
        tick();
        check("clr_func_r", r_func, 7'h00);

        // Clear colliding with an accept after 4 bits
        send_bits(6'b001111, 4);
        check("part4_key", dut_r.key_q, 6'b001111);
        key_clear = 1'b1; key_valid = 1'b1; key_in = 1'b1;
        tick();
        key_clear = 1'b0; key_valid = 1'b0; key_in = 1'b0;
        check("coll_state", 32'(dut_r.state_q), 32'(IDLE));
        check("coll_key",   dut_r.key_q, 6'b000000);
        check("coll_armed", r_armed, 0);

        // Wrong key 0,0,0,1,1,1 -> k_l = 000, k_r = 111
        tap_in = 3'b111;
        send_bits(6'b111000, 5);
        check("fresh5_armed", r_armed, 0);
        send_bit(1'b1);
        check("fresh6_armed", r_armed, 1);
        check("wrong_key",    dut_r.key_q, 6'b111000);
        check("wrong_func_c", c_func, 7'h2A);
        check("wrong_flip0",  r_flip, 0);

        // Ten flip cycles: counter growth, CNT_W=2 saturation, 1-cycle register latency
        exp_flips = 0;
        prev_c    = c_func;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_flips++;
            check($sformatf("flip_r_%0d", i), r_flip, exp_flips);
            check($sformatf("flip_s_%0d", i), s_flip, (exp_flips > 3) ? 3 : exp_flips);
            check($sformatf("lat_%0d", i), r_func, prev_c);
            prev_c = c_func;
        end
        check("wrong_func_r", r_func, 7'h2A);
        check("sat_cnt", s_flip, 2'd3);

        // tap 110 turns the flip off; counter holds
        tap_in = 3'b110;
        #1;
        check("tap110_func_c", c_func, 7'h55);
        tick();
        check("tap110_func_r", r_func, 7'h55);
        check("tap110_flip",   r_flip, 10);

        // Alternating taps: registered output trails combinational by one cycle
        for (int i = 0; i < 4; i++) begin
            tap_in = (i % 2 == 0) ? 3'b111 : 3'b110;
            #1;
            prev_c = c_func;
            check($sformatf("alt_c_%0d", i), c_func, (i % 2 == 0) ? 7'h2A : 7'h55);
            tick();
            check($sformatf("alt_r_%0d", i), r_func, prev_c);
        end
        check("alt_flipcnt", r_flip, 12);

        // Mid-load reset discards partial key
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_flip_r", r_flip, 0);
        check("rst2_flip_s", s_flip, 0);
        check("rst2_func_r", r_func, 7'h00);
        send_bits(6'b000111, 3);
        check("part3_key", dut_r.key_q, 6'b000111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_key",   dut_r.key_q, 6'b000000);
        check("midrst_state", 32'(dut_r.state_q), 32'(IDLE));
        send_bits(6'b101101, 6);
        check("reload_key",   dut_r.key_q, 6'b101101);
        check("reload_armed", r_armed, 1);

        key_valid = 1'b1;
        key_in    = 1'b0;
        tick();
        tick();
        key_valid = 1'b0;
        check("armed_valid_key", dut_r.key_q, 6'b101101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/antisat_keyed_lock.md
# antisat_keyed_lock

Parametrised, clocked Anti-SAT locking unit, the successor to our fixed 3-tap, 7-output, static-key Anti-SAT wrappers. A serial key loader with a valid/ready handshake fills a 2·IN_W-bit key register. A combinational Anti-SAT core then conditionally inverts OUT_W protected functional outputs. The unit sits between a locked netlist's primary outputs and the chip pins, and loads its key from the key-delivery interface after reset.

## Interface
- IN_W, default 3: number of tapped primary inputs; key width KEY_W = 2·IN_W (localparam).
- OUT_W, default 7: number of protected functional outputs.
- REG_OUT, default 1: 1 = registered output stage (1-cycle latency); 0 = combinational output path.
- CNT_W, default 8: width of the saturating flip counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_in  in  1  serial key bit.
- key_valid  in  1  key_in is valid this cycle.
- key_ready  out  1  loader accepts a bit this cycle.
- key_clear  in  1  erase the key and return to IDLE.
- tap_in  in  IN_W  tapped primary inputs.
- func_in  in  OUT_W  outputs of the locked netlist.
- func_out  out  OUT_W  protected outputs.
- armed  out  1  key fully loaded; the Anti-SAT path is live.
- flip_cnt  out  CNT_W  saturating count of armed cycles with flip = 1.

## Operation
- Key register key_reg[KEY_W-1:0]:
  - Bit i holds the i-th accepted bit, 0-based.
  - k_l = key_reg[IN_W-1:0]; k_r = key_reg[KEY_W-1:IN_W].
- Core logic:
  - g = AND over (tap_in ^ k_l).
  - gb = NAND over (tap_in ^ k_r).
  - flip = g & gb.
  - Any key with k_l == k_r gives flip ≡ 0.
- FSM states IDLE, LOAD, ARMED:
  - IDLE: key_ready=1. An accepted bit (valid & ready) writes bit 0, sets bit count to 1, and moves to LOAD. If KEY_W==1 it moves straight to ARMED.
  - LOAD: key_ready=1. Each accepted bit writes key_reg[count] and increments count. Accepting bit KEY_W-1 moves to ARMED.
  - ARMED: key_ready=0. key_valid is ignored.
  - In every state, key_clear=1 zeroes key_reg and count and forces IDLE next cycle. Clear wins over a simultaneous accept, and that bit is dropped.
- Output function:
  - Not armed: func_out = 0 (blanked).
  - Armed: func_out = func_in ^ {OUT_W{flip}}.
- flip_cnt increments once per ARMED cycle with flip=1 and saturates at 2^CNT_W−1. It clears on rst or key_clear.
- Reset values: state IDLE, key_reg 0, count 0, armed 0, key_ready 1 (combinational from state), func_out 0, flip_cnt 0.
- Reset mid-load discards all partial key bits.

## Timing
- A bit is accepted on the rising edge where key_valid & key_ready.
- armed rises the cycle after the KEY_W-th accept and falls the cycle after key_clear or rst.
- REG_OUT=1:
  - func_out(t+1) = f(func_in(t), tap_in(t), key_reg(t), state(t)).
  - The first unblanked output therefore appears 2 cycles after the last key accept.
- REG_OUT=0:
  - func_out follows its inputs in the same cycle.
  - It is unblanked in the first cycle armed=1.
- The flip_cnt update uses the same-cycle flip. It is visible the next cycle, independent of REG_OUT.
- Back-to-back accepts at one bit per cycle are supported: a full key loads in KEY_W cycles.

## Structure
- Package antisat_pkg holds:
  - state enum {IDLE, LOAD, ARMED};
  - function key_split(key_reg) returning k_l and k_r;
  - localparam helper for KEY_W and the counter width $clog2(KEY_W+1).
- Sub-module antisat_core: purely combinational. It takes (tap_in, k_l, k_r) and produces (g, gb, flip).
- The top level holds the FSM, the key shift/index logic, the output blanking/register stage and flip_cnt.

## Test plan
- Defaults, correct key k_l=k_r=3'b101 loaded as bits 1,0,1,1,0,1:
  - Sweep all 8 tap_in values with func_in=7'h55.
  - Required: func_out=7'h55 every armed cycle and flip_cnt stays 0.
- Wrong key k_l=3'b000, k_r=3'b111, tap_in=3'b111, func_in=7'h55:
  - Required: func_out=7'h2A and flip_cnt increments.
  - tap_in=3'b110 gives func_out=7'h55.
- Pre-key blanking:
  - After rst, drive func_in=7'h7F with no key.
  - Required: func_out=0, armed=0, key_ready=1.
  - After 6 accepts, armed=1 on the next cycle.
- Clear collision:
  - After 4 bits are accepted, assert key_clear together with key_valid.
  - Required: state IDLE, key_reg=0, and a fresh 6-bit load is needed before armed.
- Mid-load rst:
  - After 3 accepts, pulse rst, then load 6 bits.
  - Required: key_reg equals only the post-reset bits.
  - key_valid held in ARMED does not alter key_reg.
- Saturation and latency:
  - CNT_W=2 with a wrong key and flip=1 for 10 cycles: flip_cnt reads 3.
  - REG_OUT=0 versus 1: func_out differs by exactly a 1-cycle delay.
